// File: rtl/harmonic_synth_pkg.sv
// harmonic_synth_pkg: shared constants, FSM state type and harmonic gain table
// for the additive-synthesis sample engine.
package harmonic_synth_pkg;

    // Default phase modulus: one phase unit is 1/SAMPLERATE of a cycle
    localparam int SAMPLERATE   = 48000;
    localparam int HARMONICS    = 8;
    localparam int LUT_SHIFT    = 5;

    // Quadrant boundaries of the phase circle
    localparam int SR_QUARTER   = SAMPLERATE / 4;
    localparam int SR_HALF      = SAMPLERATE / 2;
    localparam int SR_3QUARTER  = (3 * SAMPLERATE) / 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_ACC,
        S_OUT
    } state_t;

    // Harmonic weight ~256/k; k=1 capped to fit 8 bits
    function automatic logic [7:0] harmonic_gain(input logic [3:0] k);
        case (k)
            4'd1:    return 8'd255;
            4'd2:    return 8'd128;
            4'd3:    return 8'd85;
            4'd4:    return 8'd64;
            4'd5:    return 8'd51;
            4'd6:    return 8'd43;
            4'd7:    return 8'd37;
            4'd8:    return 8'd32;
            default: return 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/harmonic_synth_fold.sv
// quarter_wave_fold: maps a full-circle phase onto the quarter-wave LUT
// address plus a sign flag for the lower half of the wave. Combinational.
module quarter_wave_fold #(
    parameter int SAMPLERATE = harmonic_synth_pkg::SAMPLERATE,
    parameter int LUT_SHIFT  = harmonic_synth_pkg::LUT_SHIFT
) (
    input  logic [15:0] i_ph,
    output logic [8:0]  o_addr,
    output logic        o_neg
);

    localparam logic [15:0] C_SR   = 16'(SAMPLERATE);
    localparam logic [15:0] C_Q1   = 16'(SAMPLERATE / 4);
    localparam logic [15:0] C_HALF = 16'(SAMPLERATE / 2);
    localparam logic [15:0] C_Q3   = 16'((3 * SAMPLERATE) / 4);

    logic [15:0] w_mag;

    // Mirror falling quadrants back onto the rising quarter wave
    always_comb begin
        w_mag  = i_ph;
        o_neg  = (i_ph >= C_HALF);
        if (i_ph >= C_Q3)
            w_mag = C_SR - i_ph;
        else if (i_ph >= C_HALF)
            w_mag = i_ph - C_HALF;
        else if (i_ph >= C_Q1)
            w_mag = C_HALF - i_ph;
        o_addr = 9'(w_mag >> LUT_SHIFT);
    end

endmodule

// File: rtl/harmonic_synth.sv
// harmonic_synth: per sample tick, advances the fundamental phase and sums
// up to HARMONICS gain-weighted harmonics read through the shared quarter-wave
// LUT, then emits one saturated offset-binary sample with a valid strobe.
// Optional macro HARMONIC_ALIAS_LIMIT_EN stops summing before the next
// harmonic would reach Nyquist.
module harmonic_synth #(
    parameter int SAMPLERATE = harmonic_synth_pkg::SAMPLERATE,
    parameter int HARMONICS  = harmonic_synth_pkg::HARMONICS,
    parameter int LUT_SHIFT  = harmonic_synth_pkg::LUT_SHIFT
) (
    input  logic        i_fpga_clock,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [15:0] i_frequency,
    output logic [8:0]  o_lut_addr,
    input  logic [15:0] i_lut_value,
    output logic [15:0] o_sample_out,
    output logic        o_sample_valid,
    output logic        o_busy,
    output logic        o_clip,
    output logic        o_overrun
);
    import harmonic_synth_pkg::*;

    localparam logic [16:0] C_SR  = 17'(SAMPLERATE);
    localparam logic [19:0] C_NYQ = 20'(SAMPLERATE / 2);
    localparam logic [3:0]  C_NH  = 4'(HARMONICS);

    state_t             r_state, w_next;
    logic [15:0]        r_phase0, r_p_old, r_ph, r_f;
    logic [19:0]        r_fk;
    logic [3:0]         r_k;
    logic signed [19:0] r_acc;
    logic               r_neg;

    logic [15:0]        w_f_clamped, w_phase_next, w_ph_next, w_term;
    logic [16:0]        w_phase_sum, w_ph_sum;
    logic [19:0]        w_fk_next;
    logic [23:0]        w_prod;
    logic signed [19:0] w_term_ext, w_acc_next;
    logic [15:0]        w_sat;
    logic               w_clip, w_last, w_fold_neg;
    logic [8:0]         w_fold_addr;

    quarter_wave_fold #(
        .SAMPLERATE (SAMPLERATE),
        .LUT_SHIFT  (LUT_SHIFT)
    ) u_fold (
        .i_ph   (r_ph),
        .o_addr (w_fold_addr),
        .o_neg  (w_fold_neg)
    );

    // Phase arithmetic: both sums stay below 2*SR, so one conditional subtract wraps
    assign w_f_clamped  = (i_frequency >= 16'(SAMPLERATE)) ? 16'(SAMPLERATE - 1) : i_frequency;
    assign w_phase_sum  = {1'b0, r_phase0} + {1'b0, w_f_clamped};
    assign w_phase_next = (w_phase_sum >= C_SR) ? 16'(w_phase_sum - C_SR) : w_phase_sum[15:0];
    assign w_ph_sum     = {1'b0, r_ph} + {1'b0, r_p_old};
    assign w_ph_next    = (w_ph_sum >= C_SR) ? 16'(w_ph_sum - C_SR) : w_ph_sum[15:0];
    assign w_fk_next    = r_fk + {4'b0, r_f};

    // Weighted LUT term, signed accumulate
    assign w_prod     = 24'(i_lut_value) * 24'(harmonic_gain(r_k));
    assign w_term     = 16'(w_prod >> 8);
    assign w_term_ext = signed'({4'b0, w_term});
    assign w_acc_next = r_neg ? (r_acc - w_term_ext) : (r_acc + w_term_ext);

`ifdef HARMONIC_ALIAS_LIMIT_EN
    assign w_last = (r_k == C_NH) || (w_fk_next >= C_NYQ);
`else
    assign w_last = (r_k == C_NH);
`endif

    assign o_busy = (r_state != S_IDLE);

    // Clamp the accumulator to the signed 16-bit range
    always_comb begin
        w_sat  = r_acc[15:0];
        w_clip = 1'b0;
        if (r_acc > 20'sd32767) begin
            w_sat  = 16'h7FFF;
            w_clip = 1'b1;
        end else if (r_acc < -20'sd32768) begin
            w_sat  = 16'h8000;
            w_clip = 1'b1;
        end
    end

    // State register
    always_ff @(posedge i_fpga_clock) begin
        if (i_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state: three cycles per harmonic, then one output cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_ADDR;
            S_ADDR:  w_next = S_WAIT;
            S_WAIT:  w_next = S_ACC;
            S_ACC:   w_next = w_last ? S_OUT : S_ADDR;
            S_OUT:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge i_fpga_clock) begin
        if (i_reset) begin
            r_phase0       <= '0;
            r_p_old        <= '0;
            r_ph           <= '0;
            r_f            <= '0;
            r_fk           <= '0;
            r_k            <= '0;
            r_acc          <= '0;
            r_neg          <= 1'b0;
            o_lut_addr     <= '0;
            o_sample_out   <= 16'h8000;
            o_sample_valid <= 1'b0;
            o_clip         <= 1'b0;
            o_overrun      <= 1'b0;
        end else begin
            o_sample_valid <= 1'b0;
            o_clip         <= 1'b0;
            if (i_start && (r_state != S_IDLE))
                o_overrun <= 1'b1;
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_p_old  <= r_phase0;
                    r_phase0 <= w_phase_next;
                    r_ph     <= r_phase0;
                    r_f      <= w_f_clamped;
                    r_fk     <= {4'b0, w_f_clamped};
                    r_k      <= 4'd1;
                    r_acc    <= '0;
                end
                S_ADDR: begin
                    o_lut_addr <= w_fold_addr;
                    r_neg      <= w_fold_neg;
                end
                S_ACC: begin
                    r_acc <= w_acc_next;
                    r_ph  <= w_ph_next;
                    r_fk  <= w_fk_next;
                    r_k   <= r_k + 4'd1;
                end
                S_OUT: begin
                    o_sample_out   <= w_sat ^ 16'h8000;
                    o_clip         <= w_clip;
                    o_sample_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_harmonic_synth.sv
// tb_harmonic_synth: table-driven and directed checks of harmonic_synth
// against a behavioural model of the additive sum (k*phase mod SR, fold,
// weighted sum, clamp). Honours HARMONIC_ALIAS_LIMIT_EN if defined.
module tb_harmonic_synth;

    localparam int SR = 48000;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [15:0] freq = '0;
    logic [8:0]  lut_addr;
    logic [15:0] lut_value;
    logic [15:0] sample_out;
    logic        sample_valid, busy, clip, overrun;

    harmonic_synth dut (
        .i_fpga_clock   (clk),
        .i_reset        (rst),
        .i_start        (start),
        .i_frequency    (freq),
        .o_lut_addr     (lut_addr),
        .i_lut_value    (lut_value),
        .o_sample_out   (sample_out),
        .o_sample_valid (sample_valid),
        .o_busy         (busy),
        .o_clip         (clip),
        .o_overrun      (overrun)
    );

    always #5 clk = ~clk;

    // Registered LUT model: arbitrary deterministic contents, or a forced value
    bit lut_force = 1'b0;
    int lut_fval  = 0;
    function automatic int lut_fn(input int a);
        return (a * 97 + 13) % 32768;
    endfunction
    always @(posedge clk)
        lut_value <= lut_force ? 16'(lut_fval) : 16'(lut_fn(int'(lut_addr)));

    int n_cmp = 0, n_bad = 0;
    int mphase = 0;
    int gain_tbl[8] = '{255, 128, 85, 64, 51, 43, 37, 32};
    int m_smp, m_clp, m_lat, m_n;
    int m_addr[8];
    int g_lat, g_smp, g_clp;
    int cap_addr[8];

    typedef struct {
        int f; bit frc; int fv; int inj; bit lit;
        int smp; int clp; int lat; int n; int a[8];
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: sample from old phase and clamped f, advancing model phase
    task automatic predict(input int f, input bit frc, input int fv);
        int fc, p_old, acc, ph, m, addr, v, t, sat;
        bit neg;
        fc    = (f >= SR) ? SR - 1 : f;
        p_old = mphase;
        mphase = (mphase + fc) % SR;
        acc = 0;
        m_n = 8;
`ifdef HARMONIC_ALIAS_LIMIT_EN
        for (int k = 1; k < 8; k++)
            if ((k + 1) * fc >= SR / 2) begin m_n = k; break; end
`endif
        for (int k = 1; k <= 8; k++) begin
            m_addr[k-1] = 0;
            if (k <= m_n) begin
                ph  = (k * p_old) % SR;
                neg = (ph >= SR / 2);
                if (ph >= 3 * SR / 4)  m = SR - ph;
                else if (ph >= SR / 2) m = ph - SR / 2;
                else if (ph >= SR / 4) m = SR / 2 - ph;
                else                   m = ph;
                addr = m / 32;
                m_addr[k-1] = addr;
                v = frc ? fv : lut_fn(addr);
                t = (v * gain_tbl[k-1]) / 256;
                acc = neg ? acc - t : acc + t;
            end
        end
        sat   = (acc > 32767) ? 32767 : (acc < -32768) ? -32768 : acc;
        m_clp = (acc > 32767 || acc < -32768) ? 1 : 0;
        m_smp = sat + 32768;
        m_lat = 3 * m_n + 2;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1; start = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_sample_out", int'(sample_out), 32768);
        chk("rst_valid", int'(sample_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_lut_addr", int'(lut_addr), 0);
        chk("rst_clip", int'(clip), 0);
        rst = 1'b0;
        mphase = 0;
    endtask

    // One computation: start in cycle 0, optional extra start in cycle inj
    task automatic do_run(input int f, input int inj);
        bit seen;
        freq = 16'(f);
        @(negedge clk); start = 1'b1;
        g_lat = -1; g_smp = -1; g_clp = -1; seen = 1'b0;
        for (int i = 0; i < 8; i++) cap_addr[i] = -1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            start = (n == inj);
            if (n == 1) chk("busy_cycle1", int'(busy), 1);
            if (n % 3 == 2 && n <= 23) cap_addr[(n + 1) / 3 - 1] = int'(lut_addr);
            if (sample_valid) begin
                g_lat = n; g_smp = int'(sample_out); g_clp = int'(clip);
                chk("busy_at_valid", int'(busy), 0);
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        chk("valid_seen", int'(seen), 1);
        @(negedge clk);
        chk("valid_one_cycle", int'(sample_valid), 0);
    endtask

    task automatic add(input int f, input bit frc, input int fv, input bit lit,
                       input int smp, input int clp, input int lat);
        vec_t v;
        v.f = f; v.frc = frc; v.fv = fv; v.inj = 0; v.lit = lit;
        v.smp = smp; v.clp = clp; v.lat = lat; v.n = 0;
        for (int i = 0; i < 8; i++) v.a[i] = 0;
        vecs.push_back(v);
    endtask

    initial begin
        int seen_mid;
        // ---- vector table: directed rows carry literal expectations ----
        add(0,     1'b1, 0,     1'b1, 32768, 0, 26);
        add(0,     1'b1, 32767, 1'b1, 65535, 1, 26);
        add(7000,  1'b0, 0,     1'b0, 0, 0, 0);
        add(60000, 1'b0, 0,     1'b0, 0, 0, 0);
        add(0,     1'b0, 0,     1'b0, 0, 0, 0);
        add(0,     1'b0, 0,     1'b0, 0, 0, 0);
        add(24000, 1'b0, 0,     1'b0, 0, 0, 0);
        add(36000, 1'b0, 0,     1'b0, 0, 0, 0);
        add(47999, 1'b0, 0,     1'b0, 0, 0, 0);
        for (int i = 0; i < 12; i++)
            add(int'($urandom_range(0, 65535)), 1'b0, 0, 1'b0, 0, 0, 0);
        mphase = 0;
        foreach (vecs[i]) begin
            predict(vecs[i].f, vecs[i].frc, vecs[i].fv);
            vecs[i].n = m_n;
            for (int k = 0; k < 8; k++) vecs[i].a[k] = m_addr[k];
            if (!vecs[i].lit) begin
                vecs[i].smp = m_smp; vecs[i].clp = m_clp; vecs[i].lat = m_lat;
            end
        end
`ifdef HARMONIC_ALIAS_LIMIT_EN
        vecs[2].lat = 11;
`else
        vecs[2].lat = 26;
`endif

        do_reset();

        foreach (vecs[i]) begin
            lut_force = vecs[i].frc; lut_fval = vecs[i].fv;
            do_run(vecs[i].f, vecs[i].inj);
            chk($sformatf("v%0d_latency", i), g_lat, vecs[i].lat);
            chk($sformatf("v%0d_sample", i), g_smp, vecs[i].smp);
            chk($sformatf("v%0d_clip", i), g_clp, vecs[i].clp);
            for (int k = 0; k < vecs[i].n; k++)
                chk($sformatf("v%0d_addr_h%0d", i, k + 1), cap_addr[k], vecs[i].a[k]);
        end
        lut_force = 1'b0;

        // ---- quarter frequency: second tick hits ph=12000 and ph=24000 ----
        do_reset();
        predict(12000, 1'b0, 0);
        do_run(12000, 0);
        chk("q_first_sample", g_smp, m_smp);
        predict(12000, 1'b0, 0);
        do_run(12000, 0);
        chk("q_second_sample", g_smp, m_smp);
        chk("q_addr_h1", cap_addr[0], 375);
`ifndef HARMONIC_ALIAS_LIMIT_EN
        chk("q_addr_h2", cap_addr[1], 0);
`endif

        // ---- reset mid-computation: no strobe, phase restarts ----
        do_reset();
        freq = 16'd5000;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        mphase = 0;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_sample_out", int'(sample_out), 32768);
        chk("midrst_lut_addr", int'(lut_addr), 0);
        seen_mid = 0;
        repeat (30) begin
            @(negedge clk);
            if (sample_valid) seen_mid = 1;
        end
        chk("midrst_no_valid", seen_mid, 0);
        predict(0, 1'b0, 0);
        do_run(0, 0);
        chk("midrst_after_sample", g_smp, m_smp);

        // ---- overrun: extra start in cycle 5 changes nothing but the flag ----
        chk("ovr_clear_before", int'(overrun), 0);
        predict(3000, 1'b0, 0);
        do_run(3000, 5);
        chk("ovr_latency", g_lat, m_lat);
        chk("ovr_sample", g_smp, m_smp);
        chk("ovr_set", int'(overrun), 1);
        predict(3000, 1'b0, 0);
        do_run(3000, 0);
        chk("ovr_sticky", int'(overrun), 1);
        chk("ovr_next_sample", g_smp, m_smp);
        do_reset();
        chk("ovr_cleared_by_reset", int'(overrun), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
